// File: rtl/usec_tmr_ctrl.sv
// Four-channel timer block driven by a shared, gated clock prescaler.
// Define USEC_TMR_RDBK_EN to add the rd_sel/rd_data current-count readback port.
module usec_tmr_ctrl #(
  parameter int WD = 10,
  parameter int TW = 16
) (
  input  logic          clk,
  input  logic          reset_n,
  input  logic [WD-1:0] cfg_max_cnt,
  input  logic [3:0]    cfg_tmr_en,
  input  logic [3:0]    cfg_tmr_periodic,
  input  logic          wr_req,
  input  logic [1:0]    wr_sel,
  input  logic [TW-1:0] wr_data,
  input  logic [3:0]    irq_clr,
`ifdef USEC_TMR_RDBK_EN
  input  logic [1:0]    rd_sel,
  output logic [TW-1:0] rd_data,
`endif
  output logic          tick_o,
  output logic [3:0]    tmr_irq,
  output logic [3:0]    tmr_busy
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

  state_e        state_q  [4];
  state_e        state_d  [4];
  logic [TW-1:0] count_q  [4];
  logic [TW-1:0] count_d  [4];
  logic [TW-1:0] reload_q [4];
  logic [TW-1:0] reload_d [4];
  logic [WD-1:0] pre_q, pre_d;
  logic          tick_q, tick_d;
  logic [3:0]    irq_q, irq_d;
  logic [3:0]    busy_q, busy_d;
  logic [3:0]    expire;

  // The >= compare lets a shrinking terminal value end the period at once.
  always_comb begin
    pre_d  = '0;
    tick_d = 1'b0;
    if (|busy_q) begin
      if (pre_q >= cfg_max_cnt) begin
        tick_d = 1'b1;
      end else begin
        pre_d = pre_q + WD'(1);
      end
    end
  end

  always_comb begin
    expire = '0;
    for (int i = 0; i < 4; i++) begin
      state_d[i]  = state_q[i];
      count_d[i]  = count_q[i];
      reload_d[i] = reload_q[i];
      irq_d[i]    = irq_q[i];
      if (!cfg_tmr_en[i]) begin
        state_d[i] = IDLE;
      end else if (wr_req && (wr_sel == 2'(i))) begin
        reload_d[i] = wr_data;
        count_d[i]  = wr_data;
        state_d[i]  = RUN;
      end else if ((state_q[i] == RUN) && tick_q) begin
        if (count_q[i] != '0) begin
          count_d[i] = count_q[i] - TW'(1);
        end else begin
          expire[i] = 1'b1;
          if (cfg_tmr_periodic[i]) begin
            count_d[i] = reload_q[i];
          end else begin
            state_d[i] = DONE;
          end
        end
      end else if ((state_q[i] == DONE) && irq_clr[i] && irq_q[i]) begin
        state_d[i] = IDLE;
      end
      // A same-cycle expiry wins over a clear request.
      if (expire[i]) begin
        irq_d[i] = 1'b1;
      end else if (irq_clr[i]) begin
        irq_d[i] = 1'b0;
      end
      busy_d[i] = (state_d[i] == RUN);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pre_q  <= '0;
      tick_q <= 1'b0;
      irq_q  <= '0;
      busy_q <= '0;
      for (int i = 0; i < 4; i++) begin
        state_q[i]  <= IDLE;
        count_q[i]  <= '0;
        reload_q[i] <= '0;
      end
    end else begin
      pre_q  <= pre_d;
      tick_q <= tick_d;
      irq_q  <= irq_d;
      busy_q <= busy_d;
      for (int i = 0; i < 4; i++) begin
        state_q[i]  <= state_d[i];
        count_q[i]  <= count_d[i];
        reload_q[i] <= reload_d[i];
      end
    end
  end

  assign tick_o   = tick_q;
  assign tmr_irq  = irq_q;
  assign tmr_busy = busy_q;

`ifdef USEC_TMR_RDBK_EN
  assign rd_data = (state_q[rd_sel] == IDLE) ? '0 : count_q[rd_sel];
`endif

endmodule

// File: doc/usec_tmr_ctrl.md
USEC_TMR_CTRL -- requirements
Module: usec_tmr_ctrl

Interface
REQ-001 SHALL have parameter WD, default 10: prescaler width.
REQ-002 SHALL have parameter TW, default 16: timer count width.
REQ-003 SHALL have port clk, input, 1: sole clock, all logic on rising edge.
REQ-004 SHALL have port reset_n, input, 1: asynchronous active-low reset.
REQ-005 SHALL have port cfg_max_cnt, input, WD: prescaler terminal value; tick period = cfg_max_cnt+1 clocks.
REQ-006 SHALL have port cfg_tmr_en, input, 4: per-timer enable.
REQ-007 SHALL have port cfg_tmr_periodic, input, 4: per-timer mode; 1 = periodic, 0 = one-shot.
REQ-008 SHALL have port wr_req, input, 1: single-cycle load strobe.
REQ-009 SHALL have port wr_sel, input, 2: timer index for load.
REQ-010 SHALL have port wr_data, input, TW: load value.
REQ-011 SHALL have port irq_clr, input, 4: per-timer interrupt clear, one cycle.
REQ-012 SHALL have port tick_o, output, 1: registered prescaler pulse.
REQ-013 SHALL have port tmr_irq, output, 4: sticky expiry flags.
REQ-014 SHALL have port tmr_busy, output, 4: timer in RUN state.

Function
REQ-015 SHALL run the prescaler only while any timer is in RUN; otherwise hold its count at 0 and tick_o at 0.
REQ-016 SHALL assert tick_o for exactly one cycle on the clock after the prescaler count reaches or exceeds cfg_max_cnt, then restart the count at 0.
REQ-017 SHALL use a >= compare so a cfg_max_cnt reduced mid-count terminates the period on the next cycle without counter wrap-around.
REQ-018 SHALL give cfg_max_cnt=0 a tick_o that is high every cycle while running.
REQ-019 SHALL give each timer states IDLE, RUN and DONE; tmr_busy[i] is high only in RUN.
REQ-020 SHALL, on wr_req with cfg_tmr_en[wr_sel]=1, store wr_data as reload value, copy it into the count and enter RUN from any state, restarting a running timer.
REQ-021 SHALL ignore wr_req to a disabled timer.
REQ-022 SHALL, in RUN on a cycle with tick_o=1 and count>0, decrement the count by 1.
REQ-023 SHALL, in RUN on a cycle with tick_o=1 and count=0, set tmr_irq[i]; periodic reloads the stored value and stays in RUN; one-shot enters DONE.
REQ-024 SHALL make a load of 0 expire on the first tick after the load.
REQ-025 SHALL give a load precedence over a tick in the same cycle for the same timer.
REQ-026 SHALL give set precedence over irq_clr in the same cycle.
REQ-027 SHALL, when cfg_tmr_en[i] deasserts, force timer i to IDLE within one cycle, leaving tmr_irq[i] unchanged.
REQ-028 SHALL move DONE to IDLE when irq_clr[i] clears a pending flag.
REQ-029 SHALL keep count arithmetic unsigned modulo TW bits; a count never underflows.

Reset
REQ-030 SHALL, while reset_n=0, clear the prescaler, tick_o, tmr_irq, tmr_busy, all counts and reload values, and put all timers in IDLE.
REQ-031 SHALL make reset mid-operation abort all timers with no irq generated.
REQ-032 SHALL resume operation on the first clock edge after reset_n releases.

Configuration
REQ-033 SHALL, with macro USEC_TMR_RDBK_EN defined, add input rd_sel (2 bits) and output rd_data (TW bits), where rd_data is the combinational current count of timer rd_sel (0 when IDLE).
REQ-034 SHALL, without USEC_TMR_RDBK_EN, have neither port and no readback mux.

Verification
REQ-035 SHALL cover one-shot: cfg_max_cnt=9, load timer0=3 -> tmr_irq[0] rises 40 clocks after the first tick period starts, tmr_busy[0] drops, no further ticks.
REQ-036 SHALL cover periodic: cfg_max_cnt=4, timer1 periodic, load 2 -> tmr_irq[1] set every 15 clocks; irq_clr coincident with expiry leaves flag set.
REQ-037 SHALL cover restart: reload timer2 with 5 when count=1 -> expiry delayed to 6 ticks after the reload.
REQ-038 SHALL cover shrinking prescaler: prescaler count=8, cfg_max_cnt changed 9->3 -> tick_o next cycle, then every 4 clocks.
REQ-039 SHALL cover disable/reset: deassert cfg_tmr_en[3] mid-run -> busy low next cycle, irq unchanged; assert reset_n=0 mid-run -> all outputs 0.
REQ-040 SHALL cover load 0 with cfg_max_cnt=0 -> tmr_irq set two clocks after wr_req.
